minterm_func_unit: RTL and testbench

MINTERM_FUNC_UNIT -- requirements
Module: minterm_func_unit

---
 rtl/minterm_func_unit.sv | 130 +++++++++++++
 tb/tb_minterm_func_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minterm_func_unit.sv
// Minterm function unit: N_FUNC programmable boolean functions of N_IN inputs,
// each stored as a 2**N_IN-bit minterm mask. It can evaluate one input vector
// per request, or sweep the whole truth table through the same output register.
module minterm_func_unit #(
  parameter int N_IN   = 3,
  parameter int N_FUNC = 3,
  localparam int SEL_W = (N_FUNC > 1) ? $clog2(N_FUNC) : 1,
  localparam int DEPTH = 2 ** N_IN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [DEPTH-1:0]  cfg_mask,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_FUNC-1:0] out_f,
  output logic [N_IN-1:0]   out_idx,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              sweep_done
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t              state;
  logic [DEPTH-1:0]    mask [N_FUNC];
  logic                out_valid_q;
  logic [N_FUNC-1:0]   out_f_q;
  logic [N_IN-1:0]     out_idx_q;
  logic [N_IN-1:0]     cnt;

  logic                cfg_fire;
  logic                in_fire;
  logic                sweep_go;
  logic [N_IN-1:0]     cnt_next;
  logic [N_FUNC-1:0]   eval_f;
  logic [N_FUNC-1:0]   sweep_f;

  // Status and handshake outputs are decoded from registered state only.
  assign sweep_busy = (state == SWEEP);
  assign sweep_done = (state == DONE);
  assign cfg_ready  = !sweep_busy;
  assign in_ready   = !sweep_busy && !sweep_done && (!out_valid_q || out_ready);
  assign out_valid  = out_valid_q;
  assign out_f      = out_f_q;
  assign out_idx    = out_idx_q;

  assign cfg_fire = cfg_valid && cfg_ready;
  assign in_fire  = in_valid && in_ready;
  // An evaluation accepted in the same cycle wins over a sweep request, so an
  // accepted handshake is never dropped; the sweep request is simply not taken.
  assign sweep_go = (state == IDLE) && sweep_start && !out_valid_q && !in_fire;

  // Look up every function at the requested vector and at the next sweep index,
  // using the masks as they stand before any write landing on this edge.
  always_comb begin
    cnt_next = (state == IDLE) ? '0 : cnt + N_IN'(1);
    eval_f   = '0;
    sweep_f  = '0;
    for (int k = 0; k < N_FUNC; k++) begin
      eval_f[k]  = mask[k][in_data];
      sweep_f[k] = mask[k][cnt_next];
    end
  end

  // Mask storage; a select beyond the last function matches no entry and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_FUNC; k++) mask[k] <= '0;
    end else begin
      for (int k = 0; k < N_FUNC; k++) begin
        if (cfg_fire && (int'(cfg_sel) == k)) mask[k] <= cfg_mask;
      end
    end
  end

  // Control FSM owning the single result register for both evaluations and sweeps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_f_q     <= '0;
      out_idx_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            out_valid_q <= 1'b1;
            out_idx_q   <= in_data;
            out_f_q     <= eval_f;
          end else if (sweep_go) begin
            state       <= SWEEP;
            cnt         <= '0;
            out_valid_q <= 1'b1;
            out_idx_q   <= '0;
            out_f_q     <= sweep_f;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        SWEEP: begin
          if (out_ready) begin
            if (cnt == N_IN'(DEPTH - 1)) begin
              state       <= DONE;
              out_valid_q <= 1'b0;
            end else begin
              cnt       <= cnt_next;
              out_idx_q <= cnt_next;
              out_f_q   <= sweep_f;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minterm_func_unit.sv
// Self-checking bench for minterm_func_unit (N_IN=3, N_FUNC=3) using a
// scoreboard queue filled at stimulus time and drained by an output monitor.
module tb_minterm_func_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_mask;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_f;
  logic [2:0] out_idx;
  logic       sweep_start;
  logic       sweep_busy;
  logic       sweep_done;

  int testCount = 0;
  int failCount = 0;

  logic [7:0] maskModel [3];
  logic [5:0] sbQ [$];

  minterm_func_unit #(.N_IN(3), .N_FUNC(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_sel     (cfg_sel),
    .cfg_mask    (cfg_mask),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_f       (out_f),
    .out_idx     (out_idx),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: function k at vector idx is bit idx of mask k.
  function automatic logic [2:0] expF(input logic [2:0] idx);
    logic [2:0] f;
    for (int k = 0; k < 3; k++) f[k] = maskModel[k][idx];
    return f;
  endfunction

  // Any result consumed at the coming edge is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        checkOutput("sb_unexpected_result", {29'd0, out_idx}, 32'hFFFF_FFFF);
      end else begin
        logic [5:0] e;
        e = sbQ.pop_front();
        checkOutput("sb_out_f", out_f, e[5:3]);
        checkOutput("sb_out_idx", out_idx, e[2:0]);
      end
    end
  end

  // Hard stop so a hung handshake can never stall the run.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfgWrite(input logic [1:0] sel, input logic [7:0] m);
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    cfg_mask  = m;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    if (sel < 2'd3) maskModel[sel] = m;
  endtask

  // Offer one evaluation, wait (bounded) for acceptance, and log its expected result.
  task automatic applyStimulus(input logic [2:0] d);
    int waitCnt = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waitCnt < 20) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    checkOutput("in_ready_wait", in_ready, 1);
    sbQ.push_back({expF(d), d});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic startSweep();
    sweep_start = 1'b1;
    for (int i = 0; i < 8; i++) sbQ.push_back({expF(3'(i)), 3'(i)});
    @(posedge clk);
    #1;
    sweep_start = 1'b0;
    checkOutput("sweep_busy_start", sweep_busy, 1);
    checkOutput("sweep_cfg_ready", cfg_ready, 0);
    checkOutput("sweep_in_ready", in_ready, 0);
  endtask

  task automatic waitSweepDone();
    int   waitCnt = 0;
    logic seen    = 1'b0;
    while (!seen && waitCnt < 40) begin
      @(posedge clk);
      #1;
      waitCnt++;
      if (sweep_done) seen = 1'b1;
    end
    checkOutput("sweep_done_seen", seen, 1);
    if (seen) begin
      checkOutput("done_out_valid", out_valid, 0);
      checkOutput("done_sweep_busy", sweep_busy, 0);
    end
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", sweep_done, 0);
    checkOutput("busy_after_done", sweep_busy, 0);
    checkOutput("sweep_all_consumed", sbQ.size(), 0);
  endtask

  initial begin
    int   waitCnt;
    logic doneSeen;

    rst_n       = 1'b0;
    cfg_valid   = 1'b0;
    cfg_sel     = '0;
    cfg_mask    = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;
    sweep_start = 1'b0;
    for (int k = 0; k < 3; k++) maskModel[k] = '0;

    // Reset state
    idle(2);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_f", out_f, 0);
    checkOutput("rst_out_idx", out_idx, 0);
    checkOutput("rst_sweep_busy", sweep_busy, 0);
    checkOutput("rst_sweep_done", sweep_done, 0);
    checkOutput("rst_cfg_ready", cfg_ready, 1);
    checkOutput("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // Program masks and evaluate two vectors
    cfgWrite(2'd0, 8'h94);
    cfgWrite(2'd1, 8'h09);
    cfgWrite(2'd2, 8'h9D);
    applyStimulus(3'd4);
    checkOutput("eval4_latency_valid", out_valid, 1);
    checkOutput("eval4_out_f", out_f, 3'b101);
    checkOutput("eval4_out_idx", out_idx, 3'd4);
    applyStimulus(3'd3);
    checkOutput("eval3_out_f", out_f, 3'b110);
    idle(2);
    checkOutput("eval_drained_valid", out_valid, 0);

    // Evaluation held under back-pressure
    out_ready = 1'b0;
    applyStimulus(3'd7);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_eval_valid", out_valid, 1);
      checkOutput("stall_eval_out_f", out_f, expF(3'd7));
      checkOutput("stall_eval_out_idx", out_idx, 3'd7);
      checkOutput("stall_eval_in_ready", in_ready, 0);
      idle(1);
    end
    out_ready = 1'b1;
    idle(2);

    // Full sweep at full rate
    startSweep();
    waitSweepDone();

    // Sweep stalled at idx 2
    out_ready = 1'b0;
    startSweep();
    out_ready = 1'b1;
    idle(2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_sweep_idx", out_idx, 3'd2);
      checkOutput("stall_sweep_out_f", out_f, expF(3'd2));
      checkOutput("stall_sweep_in_ready", in_ready, 0);
      checkOutput("stall_sweep_busy", sweep_busy, 1);
      idle(1);
    end
    out_ready = 1'b1;
    waitSweepDone();

    // Write and evaluation in the same cycle: evaluation sees the old mask
    cfg_valid = 1'b1;
    cfg_sel   = 2'd0;
    cfg_mask  = 8'hFF;
    applyStimulus(3'd1);
    cfg_valid = 1'b0;
    maskModel[0] = 8'hFF;
    checkOutput("same_cycle_old_f0", out_f[0], 0);
    idle(1);
    applyStimulus(3'd1);
    checkOutput("after_write_new_f0", out_f[0], 1);
    idle(2);

    // Out-of-range select is dropped; a sweep reads back every mask bit
    cfgWrite(2'd3, 8'h55);
    idle(1);
    startSweep();
    waitSweepDone();

    // sweep_start while a result is pending is ignored and not remembered
    out_ready = 1'b0;
    applyStimulus(3'd2);
    sweep_start = 1'b1;
    idle(1);
    sweep_start = 1'b0;
    checkOutput("ignored_start_busy", sweep_busy, 0);
    checkOutput("ignored_start_idx", out_idx, 3'd2);
    out_ready = 1'b1;
    idle(3);
    checkOutput("ignored_start_not_queued", sweep_busy, 0);
    checkOutput("ignored_start_valid", out_valid, 0);

    // Reset in the middle of a sweep
    startSweep();
    waitCnt = 0;
    while (out_idx != 3'd5 && waitCnt < 20) begin
      idle(1);
      waitCnt++;
    end
    checkOutput("rst_sweep_reach5", out_idx, 3'd5);
    rst_n = 1'b0;
    sbQ.delete();
    for (int k = 0; k < 3; k++) maskModel[k] = '0;
    doneSeen = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_sweep_busy", sweep_busy, 0);
    for (int i = 0; i < 6; i++) begin
      if (sweep_done) doneSeen = 1'b1;
      if (i == 3) rst_n = 1'b1;
      idle(1);
    end
    checkOutput("midrst_no_done", doneSeen, 0);
    checkOutput("midrst_busy_after", sweep_busy, 0);
    applyStimulus(3'd5);
    checkOutput("midrst_eval_f", out_f, 3'b000);
    idle(1);
    startSweep();
    waitSweepDone();

    idle(2);
    checkOutput("final_sb_empty", sbQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
